reg_bank_8x4: RTL
=================

// Module: reg_bank_8x4
// PURPOSE
//   Eight-entry, 4-bit-wide register bank with one write port and two read ports.
//   It is the storage stage directly upstream of the 8-way 4-bit select tree.
//   Each read port drives one mux4x8to4_c instance, with the 3-bit read address
//   as select. Per-entry valid bits tell consumers which entries hold written data.
// PARAMETERS
//   BYPASS     1     1: a read whose address matches an active write returns wr_data the same cycle; 0: returns the stored value
//   RESET_VAL  4'h0  value loaded into every entry on reset and on clr
// PORTS
//   clk        in   1  rising-edge clock
//   reset_n    in   1  asynchronous reset, active-low
//   clr        in   1  synchronous clear of all entries and valid bits
//   wr_en      in   1  write strobe
//   wr_addr    in   3  write entry index 0..7
//   wr_data    in   4  write data
//   rd_addr_a  in   3  read port A entry index
//   rd_addr_b  in   3  read port B entry index
//   rd_data_a  out  4  read port A data
//   rd_data_b  out  4  read port B data
//   valid_a    out  1  entry rd_addr_a has been written since the last reset/clr
//   valid_b    out  1  entry rd_addr_b has been written since the last reset/clr
// BEHAVIOUR
//   - Storage: entry[0..7] are 4-bit flops; vld[0..7] are 1-bit flops.
//   - reset_n low (asynchronous): every entry = RESET_VAL, every vld = 0.
//     While reset_n is low, rd_data_a/b = RESET_VAL and valid_a/b = 0 for any
//     rd_addr, and writes are ignored.
//   - Deassertion of reset_n takes effect from the next rising edge.
//   - Reset asserted mid-write: the write is lost. No partial update of any entry.
//   - Write: on a rising clk edge with wr_en=1 and clr=0:
//     entry[wr_addr] <= wr_data and vld[wr_addr] <= 1. No other entry changes.
//     Write latency is 1 cycle.
//   - clr=1 on a rising edge: every entry <= RESET_VAL, every vld <= 0.
//     clr has priority over a simultaneous wr_en, so the write is dropped.
//   - Read: purely combinational, 0-cycle latency from rd_addr to rd_data.
//     rd_data_x = entry[rd_addr_x] and valid_x = vld[rd_addr_x].
//     Data selection goes through mux4x8to4_c (in_7..in_0 = entry[7..0]).
//   - Bypass (BYPASS=1): if wr_en=1, clr=0, reset_n=1 and rd_addr_x == wr_addr,
//     then rd_data_x = wr_data and valid_x = 1 in the same cycle.
//     This applies to each port independently; both ports may bypass at once.
//   - BYPASS=0: a read of the entry being written returns the old value until
//     after the edge.
//   - Both read ports may address the same entry. There is no conflict and both
//     return identical data.
//   - Widths: addresses are exactly 3 bits, so every value 0..7 is legal.
//     There is no out-of-range case and no wrap logic.
//   - No X propagation: every output is defined in every cycle after reset.
// TESTING
//   - Reset: reset_n=0, sweep rd_addr_a/b over 0..7 -> rd_data=4'h0, valid=0
//     on both ports at every address.
//   - Write/read all: write entry i = 4'hF-i for i=0..7, one per cycle.
//     Then read A=i, B=7-i -> A=F-i, B=8+i, valid_a=valid_b=1.
//   - Bypass: BYPASS=1, entry3=4'h2. Same cycle: wr_en=1, wr_addr=3, wr_data=4'hA,
//     rd_addr_a=3 -> rd_data_a=4'hA before the edge.
//     Repeat with BYPASS=0 -> rd_data_a=4'h2 before the edge and 4'hA after it.
//   - clr vs write: entry5=4'h7, then clr=1 with wr_en=1, wr_addr=5, wr_data=4'h9
//     -> after the edge entry5=4'h0 and valid=0 for all entries.
//   - Async reset mid-stream: pulse reset_n low between edges while wr_en=1
//     -> outputs go to 4'h0/0 immediately, with no clock edge needed,
//     and the pending write is never committed.
//   - Partial valid: write only entries 1 and 6 -> valid=1 only at addresses 1
//     and 6; rd_data=4'h0 at every other address.

Source files
------------

// File: rtl/reg_bank_8x4.sv
// Eight-entry 4-bit register bank: one write port, two combinational read ports
// with per-entry valid bits and optional same-cycle write-to-read bypass.

module mux4x8to4_c (
    input  logic [3:0] in_0,
    input  logic [3:0] in_1,
    input  logic [3:0] in_2,
    input  logic [3:0] in_3,
    input  logic [3:0] in_4,
    input  logic [3:0] in_5,
    input  logic [3:0] in_6,
    input  logic [3:0] in_7,
    input  logic [2:0] i_sel,
    output logic [3:0] o_data
);
    always_comb begin
        o_data = in_0;
        case (i_sel)
            3'd0: o_data = in_0;
            3'd1: o_data = in_1;
            3'd2: o_data = in_2;
            3'd3: o_data = in_3;
            3'd4: o_data = in_4;
            3'd5: o_data = in_5;
            3'd6: o_data = in_6;
            3'd7: o_data = in_7;
            default: o_data = in_0;
        endcase
    end
endmodule

module reg_bank_8x4 #(
    parameter bit         BYPASS    = 1'b1,
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [2:0] rd_addr_a,
    input  logic [2:0] rd_addr_b,
    output logic [3:0] rd_data_a,
    output logic [3:0] rd_data_b,
    output logic       valid_a,
    output logic       valid_b
);
    logic [3:0] r_entry [8];
    logic [7:0] r_vld;

    logic       w_wr_act;
    logic       w_byp_a;
    logic       w_byp_b;
    logic [3:0] w_mux_a;
    logic [3:0] w_mux_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_entry <= '{default: RESET_VAL};
            r_vld   <= '0;
        end else if (clr) begin
            r_entry <= '{default: RESET_VAL};
            r_vld   <= '0;
        end else if (wr_en) begin
            r_entry[wr_addr] <= wr_data;
            r_vld[wr_addr]   <= 1'b1;
        end
    end

    // Bypass is gated by reset_n so outputs stay at reset values while reset is held.
    assign w_wr_act = BYPASS && reset_n && wr_en && !clr;
    assign w_byp_a  = w_wr_act && (rd_addr_a == wr_addr);
    assign w_byp_b  = w_wr_act && (rd_addr_b == wr_addr);

    mux4x8to4_c u_mux_a (
        .in_0   (r_entry[0]),
        .in_1   (r_entry[1]),
        .in_2   (r_entry[2]),
        .in_3   (r_entry[3]),
        .in_4   (r_entry[4]),
        .in_5   (r_entry[5]),
        .in_6   (r_entry[6]),
        .in_7   (r_entry[7]),
        .i_sel  (rd_addr_a),
        .o_data (w_mux_a)
    );

    mux4x8to4_c u_mux_b (
        .in_0   (r_entry[0]),
        .in_1   (r_entry[1]),
        .in_2   (r_entry[2]),
        .in_3   (r_entry[3]),
        .in_4   (r_entry[4]),
        .in_5   (r_entry[5]),
        .in_6   (r_entry[6]),
        .in_7   (r_entry[7]),
        .i_sel  (rd_addr_b),
        .o_data (w_mux_b)
    );

    assign rd_data_a = w_byp_a ? wr_data : w_mux_a;
    assign rd_data_b = w_byp_b ? wr_data : w_mux_b;
    assign valid_a   = w_byp_a | r_vld[rd_addr_a];
    assign valid_b   = w_byp_b | r_vld[rd_addr_b];
endmodule
